// File: rtl/fp8_dot_accumulator_pkg.sv
// rtl/fp8_dot_accumulator_pkg.sv - shared minifloat format constants, FSM states and field helpers
//
// Purpose: format definition shared by the accumulator, the normalizer and the
// upstream multiplier. Format: bit7 sign, [6:4] biased exponent (bias 3),
// [3:0] fraction with a hidden leading 1. 8'h00 and 8'h80 both encode zero.
// Ports: none (package).
package fp8_dot_accumulator_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int BIAS  = 3;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;

  localparam logic [FP_W-1:0] FP_ZERO    = '0;
  localparam logic [FP_W-2:0] FP_MAX_MAG = '1;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } acc_state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] v);
    return v[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[FP_W-2 -: EXP_W];
  endfunction

  // Significand with the hidden 1 restored.
  function automatic logic [SIG_W-1:0] fp_sig(input logic [FP_W-1:0] v);
    return {1'b1, v[MAN_W-1:0]};
  endfunction

  // Both signed zeros count as zero.
  function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
    return v[FP_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fp8_normalize.sv
// rtl/fp8_normalize.sv - combinational minifloat normalize with saturate and flush
//
// Purpose: takes a raw sum (sign, unnormalized 6-bit significand, exponent of
// the aligned operands) and produces a packed minifloat.
// Ports:
//   sign    in   sign of the raw result
//   exp_in  in   biased exponent the significand is expressed at
//   sig_in  in   6-bit significand, bit4 is the hidden-1 position, bit5 carry
//   result  out  packed minifloat (saturated or flushed as needed)
//   sat     out  exponent overflowed and the result was clamped
module fp8_normalize
  import fp8_dot_accumulator_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W+1:0] sig_in,
  output logic [FP_W-1:0]  result,
  output logic             sat
);

  localparam logic signed [EXP_W+1:0] EXP_HI  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

  logic signed [EXP_W+1:0] exp_ext;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] lshift;
  logic [MAN_W-1:0]        frac_n;

  always_comb begin
    exp_ext = $signed({2'b00, exp_in});

    // Priority encoder: the highest set bit below the carry wins because it is
    // visited last.
    lshift = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (sig_in[i]) lshift = (EXP_W+2)'(MAN_W - i);
    end

    if (sig_in[MAN_W+1]) begin
      exp_n  = exp_ext + EXP_ONE;
      frac_n = sig_in[MAN_W:1];
    end else begin
      exp_n  = exp_ext - lshift;
      frac_n = MAN_W'(sig_in[MAN_W:0] << lshift);
    end

    sat = 1'b0;
    if (sig_in == '0) begin
      result = FP_ZERO;
    end else if (exp_n > EXP_HI) begin
      result = {sign, FP_MAX_MAG};
      sat    = 1'b1;
    end else if (exp_n[EXP_W+1]) begin
      result = FP_ZERO;
    end else begin
      result = {sign, exp_n[EXP_W-1:0], frac_n};
    end
  end

endmodule

// File: rtl/fp8_dot_accumulator.sv
// rtl/fp8_dot_accumulator.sv - sequential minifloat dot-product accumulator
//
// Purpose: accepts minifloat products over valid/ready, folds each one into an
// accumulator through ALIGN/ADD/NORM steps and presents the sum after the
// product flagged last has been added.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   prod_valid   product valid          prod_ready  block can accept (WAIT only)
//   prod_data    minifloat product      prod_last   final term of the vector
//   sum_valid    result available       sum_ready   consumer takes the result
//   sum_data     accumulated result     sum_count   products folded in (wraps)
//   sat          some step of this vector saturated
// Build option: FP8_ACC_STICKY_SAT_EN freezes the accumulator once saturated.
module fp8_dot_accumulator
  import fp8_dot_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [FP_W-1:0]  prod_data,
  input  logic             prod_last,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [FP_W-1:0]  sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sat
);

  acc_state_t state_q, state_d;

  logic [FP_W-1:0]  acc_q;
  logic [FP_W-1:0]  prod_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  // Aligned operands (ALIGN -> ADD).
  logic [SIG_W-1:0] a_sig_q, b_sig_q;
  logic             a_sign_q, b_sign_q;
  logic [EXP_W-1:0] exp_q;
  logic             byp_q;
  logic [FP_W-1:0]  byp_val_q;

  // Raw sum (ADD -> NORM).
  logic [SIG_W:0]   sum_sig_q;
  logic             sum_sign_q;

  logic [EXP_W-1:0] exp_a, exp_b, exp_big;
  logic [SIG_W-1:0] sig_a_al, sig_b_al;
  logic [SIG_W:0]   sum_sig_d;
  logic             sum_sign_d;
  logic [FP_W-1:0]  norm_result;
  logic             norm_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        prod_ready = !rst;
        if (prod_valid) state_d = ST_ALIGN;
      end
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = last_q ? ST_DONE : ST_WAIT;
      ST_DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Shifting the 5-bit significand by 5 or more naturally yields 0, and the
  // dropped bits are simply truncated.
  always_comb begin
    exp_a = fp_exp(acc_q);
    exp_b = fp_exp(prod_q);
    if (exp_a >= exp_b) begin
      exp_big  = exp_a;
      sig_a_al = fp_sig(acc_q);
      sig_b_al = fp_sig(prod_q) >> (exp_a - exp_b);
    end else begin
      exp_big  = exp_b;
      sig_a_al = fp_sig(acc_q) >> (exp_b - exp_a);
      sig_b_al = fp_sig(prod_q);
    end
  end

  // Sign-magnitude add; equal magnitudes of opposite sign give +0.
  always_comb begin
    sum_sig_d  = '0;
    sum_sign_d = 1'b0;
    if (a_sign_q == b_sign_q) begin
      sum_sig_d  = {1'b0, a_sig_q} + {1'b0, b_sig_q};
      sum_sign_d = a_sign_q;
    end else if (a_sig_q > b_sig_q) begin
      sum_sig_d  = {1'b0, a_sig_q - b_sig_q};
      sum_sign_d = a_sign_q;
    end else if (b_sig_q > a_sig_q) begin
      sum_sig_d  = {1'b0, b_sig_q - a_sig_q};
      sum_sign_d = b_sign_q;
    end
  end

  fp8_normalize u_norm (
    .sign   (sum_sign_q),
    .exp_in (exp_q),
    .sig_in (sum_sig_q),
    .result (norm_result),
    .sat    (norm_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= FP_ZERO;
      prod_q     <= FP_ZERO;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      a_sig_q    <= '0;
      b_sig_q    <= '0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
      exp_q      <= '0;
      byp_q      <= 1'b0;
      byp_val_q  <= FP_ZERO;
      sum_sig_q  <= '0;
      sum_sign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (prod_valid) begin
            prod_q <= prod_data;
            last_q <= prod_last;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        ST_ALIGN: begin
          a_sig_q  <= sig_a_al;
          b_sig_q  <= sig_b_al;
          a_sign_q <= fp_sign(acc_q);
          b_sign_q <= fp_sign(prod_q);
          exp_q    <= exp_big;
          // A zero operand leaves the other one untouched, bit for bit.
          byp_q     <= fp_is_zero(acc_q) | fp_is_zero(prod_q);
          byp_val_q <= fp_is_zero(prod_q) ? acc_q : prod_q;
        end
        ST_ADD: begin
          sum_sig_q  <= sum_sig_d;
          sum_sign_q <= sum_sign_d;
        end
        ST_NORM: begin
`ifdef FP8_ACC_STICKY_SAT_EN
          if (!sat_q) acc_q <= byp_q ? byp_val_q : norm_result;
`else
          acc_q <= byp_q ? byp_val_q : norm_result;
`endif
          sat_q <= sat_q | (norm_sat & !byp_q);
        end
        ST_DONE: begin
          if (sum_ready) begin
            acc_q <= FP_ZERO;
            cnt_q <= '0;
            sat_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_data  = acc_q;
  assign sum_count = cnt_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// tb/tb_fp8_dot_accumulator.sv - self-checking bench for fp8_dot_accumulator
module tb_fp8_dot_accumulator;

  localparam int CNT_W = 8;
  localparam int BIAS  = 3;
  localparam int MANW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             prod_valid;
  logic             prod_ready;
  logic [7:0]       prod_data;
  logic             prod_last;
  logic             sum_valid;
  logic             sum_ready;
  logic [7:0]       sum_data;
  logic [CNT_W-1:0] sum_count;
  logic             sat;

  int checks   = 0;
  int failures = 0;

  // Reference state: value of the running sum, saturation flag, count.
  logic [7:0] m_acc;
  bit         m_sat;
  int         m_cnt;
  logic [7:0] vec[$];

  always #5 clk = ~clk;

  fp8_dot_accumulator #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .sum_count  (sum_count),
    .sat        (sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed value in units of 2^-(BIAS+MANW).
  function automatic int fp_val(input logic [7:0] v);
    int mag;
    if (v[6:0] == 7'd0) return 0;
    mag = (16 + int'(v[3:0])) << v[6:4];
    return v[7] ? -mag : mag;
  endfunction

  // Drop everything finer than the LSB of an operand at exponent e.
  function automatic int trunc_to(input int v, input int e);
    int mag;
    mag = v < 0 ? -v : v;
    mag = (mag >> e) << e;
    return v < 0 ? -mag : mag;
  endfunction

  function automatic logic [7:0] fp_enc(input int v, output bit s);
    int mag, p, e;
    logic neg;
    s   = 1'b0;
    neg = v < 0;
    mag = neg ? -v : v;
    p   = -1;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    if (mag == 0) return 8'h00;
    e = p - MANW;
    if (e > 7) begin
      s = 1'b1;
      return {neg, 7'h7F};
    end
    if (e < 0) return 8'h00;
    return {neg, 3'(e), 4'((mag >> e) - 16)};
  endfunction

  function automatic void model_accept(input logic [7:0] p);
    int ea, eb, big, a, b;
    bit s;
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifdef FP8_ACC_STICKY_SAT_EN
    if (m_sat) return;
`endif
    if (p[6:0] == 7'd0) return;
    if (m_acc[6:0] == 7'd0) begin
      m_acc = p;
      return;
    end
    ea  = int'(m_acc[6:4]);
    eb  = int'(p[6:4]);
    big = ea > eb ? ea : eb;
    a   = trunc_to(fp_val(m_acc), big);
    b   = trunc_to(fp_val(p), big);
    m_acc = fp_enc(a + b, s);
    m_sat = m_sat | s;
  endfunction

  function automatic void model_clear();
    m_acc = 8'h00;
    m_sat = 1'b0;
    m_cnt = 0;
  endfunction

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (prod_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 40), 1);
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = last;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    model_accept(d);
  endtask

  // Entered just after the accept edge of the last product (edge 1).
  task automatic collect(input int hold, input int exp_data);
    check("lat_e1", 32'(sum_valid), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("lat_early", 32'(sum_valid), 0);
    end
    @(posedge clk);
    #1;
    check("sum_valid", 32'(sum_valid), 1);
    check("sum_data", 32'(sum_data), 32'(m_acc));
    check("sum_count", 32'(sum_count), 32'(m_cnt));
    check("sat", 32'(sat), 32'(m_sat));
    if (exp_data >= 0) check("sum_data_spec", 32'(sum_data), 32'(exp_data));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(sum_valid), 1);
      check("hold_data", 32'(sum_data), 32'(m_acc));
      check("hold_count", 32'(sum_count), 32'(m_cnt));
      check("hold_ready", 32'(prod_ready), 0);
    end
    @(negedge clk);
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    check("clr_valid", 32'(sum_valid), 0);
    check("clr_count", 32'(sum_count), 0);
    check("clr_data", 32'(sum_data), 0);
    check("clr_sat", 32'(sat), 0);
    check("clr_ready", 32'(prod_ready), 1);
    model_clear();
  endtask

  task automatic run_vec(input int hold, input int exp_data);
    for (int i = 0; i < vec.size(); i++) send(vec[i], i == vec.size() - 1);
    collect(hold, exp_data);
  endtask

  initial begin
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod_data  = 8'h00;
    prod_last  = 1'b0;
    sum_ready  = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(prod_ready), 0);
    check("rst_valid", 32'(sum_valid), 0);
    check("rst_data", 32'(sum_data), 0);
    check("rst_count", 32'(sum_count), 0);
    check("rst_sat", 32'(sat), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(prod_ready), 1);

    vec = '{8'h30};             run_vec(0, 'h30);
    vec = '{8'h30, 8'h30};      run_vec(0, 'h40);
    vec = '{8'h38, 8'hB0};      run_vec(0, 'h20);
    vec = '{8'h30, 8'hB0};      run_vec(0, 'h00);
    vec = '{8'h7F, 8'h7F};      run_vec(0, 'h7F);
    vec = '{8'h7F, 8'h7F, 8'hF0}; run_vec(0, -1);

    // Back-pressure in DONE.
    vec = '{8'h38, 8'h30};      run_vec(10, -1);

    // A held prod_valid is taken once per pass through WAIT.
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = 8'h00;
    prod_last  = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    prod_valid = 1'b0;
    repeat (3) model_accept(8'h00);
    check("held_count", 32'(sum_count), 3);
    send(8'h30, 1'b1);
    collect(0, 'h30);

    // Counter wrap: 257 products leave a count of 1.
    for (int i = 0; i < 256; i++) send(8'h00, 1'b0);
    send(8'h30, 1'b1);
    collect(0, 'h30);

    // Asynchronous reset while in ADD aborts the vector.
    send(8'h30, 1'b0);
    send(8'h38, 1'b0);
    send(8'h28, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(prod_ready), 0);
    check("arst_valid", 32'(sum_valid), 0);
    check("arst_data", 32'(sum_data), 0);
    check("arst_count", 32'(sum_count), 0);
    check("arst_sat", 32'(sat), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    vec = '{8'h38};
    run_vec(0, 'h38);

    // Random vectors against the reference model.
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 6);
      vec = {};
      for (int j = 0; j < len; j++) vec.push_back(8'($urandom));
      run_vec($urandom_range(0, 3), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
